serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Multi-cycle, bit-serial 8-bit adder: the additive counterpart to the combinational subtractor in the 8-bit ALU.
- Adds A + B + Cin one bit per clock, LSB first, through a single full-adder cell.
- Used where area matters more than latency.
- Sits beside the combinational ALU datapath and is driven by a start/done handshake from the ALU control.

Parameters:
WIDTH, 8, operand and result width in bits (all behaviour below is stated for WIDTH=8).
CNT_W, 3, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
A  input  WIDTH  augend; latched on accepted start.
B  input  WIDTH  addend; latched on accepted start.
Cin  input  1  carry-in; latched on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when a result becomes valid.
Sum  output  WIDTH  registered result; holds until the next completion.
Cout  output  1  carry out of bit WIDTH-1.
Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - busy=0, done=0, Sum=0, Cout=0, Ovf=0.
  - Internal shift registers, carry and counter cleared.
  - Reset dominates start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> load opA=A, opB=B, carry=Cin, cnt=0, and go to RUN.
  - Otherwise stay.
- RUN (busy=1), one bit per edge:
  - s = opA[0]^opB[0]^carry.
  - carry <= maj(opA[0], opB[0], carry).
  - opA and opB shift right by 1.
  - Result shift register shifts right with s inserted at MSB.
  - cnt increments.
  - On the edge where cnt==WIDTH-1: go to DONE, register Sum (full result), Cout (final carry) and Ovf (carry-in to MSB XOR final carry), and set done=1.
  - start is ignored while in RUN; A, B and Cin changes have no effect.
- DONE (done=1 for exactly this one cycle):
  - start=1 -> load new operands, go to RUN (back-to-back operation).
  - Otherwise -> IDLE.
- Latency:
  - start accepted at edge k; done=1 and Sum/Cout/Ovf valid after edge k+WIDTH (8 cycles).
  - Throughput: one result per WIDTH+1 cycles back-to-back.
- Output stability:
  - Sum, Cout and Ovf change only at completion or reset; never intermediate values.
  - busy and done are never high simultaneously.
- Arithmetic:
  - Unsigned result {Cout,Sum} = A+B+Cin, modulo 2^(WIDTH+1).
  - Ovf uses two's-complement interpretation.
- Boundary cases:
  - Carry wraps out of bit 7 into Cout only; carry is not retained between operations.
  - A new operation always uses the latched Cin.
  - Reset mid-RUN aborts the operation: no done pulse, outputs zeroed.

Test Plan:
- Reset then A=0, B=0, Cin=0, start -> busy for 8 cycles; done pulse 8 cycles after start; Sum=0, Cout=0, Ovf=0.
- A=15, B=1, Cin=0 -> Sum=16, Cout=0, Ovf=0.
- A=255, B=1 -> Sum=0, Cout=1, Ovf=0.
- A=255, B=255 -> Sum=254, Cout=1.
- A=127, B=1 -> Sum=128, Ovf=1, Cout=0.
- A=240, B=15, Cin=1 -> Sum=0, Cout=1.
- Second start pulsed mid-RUN with A=1, B=1 -> ignored; result is that of the first operands.
- Start asserted during the DONE cycle -> next result 9 cycles after the previous done.
- rst asserted at RUN cycle 4 -> done never pulses; Sum=Cout=Ovf=0; busy=0 next cycle.
- Sum stability: Sum holds the previous result (e.g. 16) throughout the next RUN until its done.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell computes A + B + Cin LSB first, one bit per clock.
// Sum/Cout/Ovf are registered only at completion, so intermediate values are never visible.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             bit_s, bit_c;

  always_comb begin
    bit_s   = opa_q[0] ^ opb_q[0] ^ carry_q;
    bit_c   = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = B;
          carry_d = Cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = bit_c;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB, bit_c the carry out of it
          state_d = DONE;
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random operations checked against plain integer arithmetic.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst, start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0] prev_sum;
  logic       prev_cout, prev_ovf;

  serial_adder #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .Sum(sum), .Cout(cout), .Ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one operation from IDLE or DONE and returns in the cycle where done is seen.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input bit glitch);
    int          n;
    int          total;
    int          stotal;
    logic [8:0]  full;
    logic        exp_ovf;
    bit          busy_ok;
    bit          quiet_ok;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    check("busy_after_start", {15'd0, busy}, 16'd1);
    n = 0;
    busy_ok = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (glitch && i == 3) begin
        start = 1'b1; a = 8'd1; b = 8'd1; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        n = i;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (sum !== prev_sum || cout !== prev_cout || ovf !== prev_ovf) quiet_ok = 1'b0;
    end
    start = 1'b0;
    check("latency", 16'(n), 16'd8);
    check("busy_during_run", {15'd0, busy_ok}, 16'd1);
    check("outputs_stable_during_run", {15'd0, quiet_ok}, 16'd1);
    total   = int'(ta) + int'(tb_v) + int'(tc);
    full    = 9'(total);
    stotal  = int'($signed(ta)) + int'($signed(tb_v)) + int'(tc);
    exp_ovf = (stotal > 127) || (stotal < -128);
    check("sum",  {8'd0, sum},   {8'd0, full[7:0]});
    check("cout", {15'd0, cout}, {15'd0, full[8]});
    check("ovf",  {15'd0, ovf},  {15'd0, exp_ovf});
    check("busy_at_done", {15'd0, busy}, 16'd0);
    prev_sum  = full[7:0];
    prev_cout = full[8];
    prev_ovf  = exp_ovf;
  endtask

  task automatic to_idle();
    tick();
    check("done_one_cycle", {15'd0, done}, 16'd0);
    check("idle_not_busy", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick();
    tick();
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_sum",  {8'd0, sum},   16'd0);
    check("rst_cout", {15'd0, cout}, 16'd0);
    check("rst_ovf",  {15'd0, ovf},  16'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle_after_rst", {15'd0, busy}, 16'd0);
    prev_sum = 8'd0; prev_cout = 1'b0; prev_ovf = 1'b0;

    run_op(8'd0,   8'd0,   1'b0, 1'b0); to_idle();
    run_op(8'd15,  8'd1,   1'b0, 1'b0); to_idle();
    run_op(8'd255, 8'd1,   1'b0, 1'b0); to_idle();
    run_op(8'd255, 8'd255, 1'b0, 1'b0); to_idle();
    run_op(8'd127, 8'd1,   1'b0, 1'b0); to_idle();
    run_op(8'd240, 8'd15,  1'b1, 1'b0); to_idle();
    run_op(8'd128, 8'd128, 1'b0, 1'b0); to_idle();
    run_op(8'd100, 8'd50,  1'b0, 1'b1); to_idle();
    // back-to-back: start held during the DONE cycle
    run_op(8'd15,  8'd1,   1'b0, 1'b0);
    run_op(8'd127, 8'd0,   1'b1, 1'b0);
    run_op(8'd200, 8'd100, 1'b1, 1'b0); to_idle();

    for (int k = 0; k < 25; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) to_idle();
    end
    to_idle();

    a = 8'd200; b = 8'd100; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("busy_before_abort", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_sum",  {8'd0, sum},   16'd0);
    check("abort_cout", {15'd0, cout}, 16'd0);
    check("abort_ovf",  {15'd0, ovf},  16'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", {15'd0, seen_done}, 16'd0);
    prev_sum = 8'd0; prev_cout = 1'b0; prev_ovf = 1'b0;

    run_op(8'd1, 8'd2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
